shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter: width, default 8, register length in bits; legal values >= 2.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: peripheralClkEdge  input  1  shift-enable strobe; high for one clk cycle per peripheral clock edge.
REQ-005 Port: parallelLoad  input  1  load-enable; copies parallelDataIn into the register.
REQ-006 Port: parallelDataIn  input  width  parallel load data.
REQ-007 Port: serialDataIn  input  1  serial bit shifted into the LSB.
REQ-008 Port: parallelDataOut  output  width  current register contents.
REQ-009 Port: serialDataOut  output  1  current register MSB, bit [width-1].

Function
REQ-010 The block SHALL hold one width-bit register; it is the only state element.
REQ-011 parallelDataOut SHALL equal the register continuously (combinational from the register, no extra pipeline stage).
REQ-012 serialDataOut SHALL equal register[width-1] continuously.
REQ-013 Per rising clk, the register update SHALL follow strict priority: reset > peripheralClkEdge > parallelLoad > hold.
REQ-014 Shift (peripheralClkEdge=1, reset=0): register <= {register[width-2:0], serialDataIn}; shift left, MSB discarded, serialDataIn enters bit 0.
REQ-015 Load (parallelLoad=1, peripheralClkEdge=0, reset=0): register <= parallelDataIn.
REQ-016 Hold (all controls 0): register unchanged.
REQ-017 Simultaneous peripheralClkEdge=1 and parallelLoad=1: shift SHALL occur; parallelDataIn ignored that cycle.
REQ-018 Latency: each update SHALL be visible on both outputs immediately after the triggering rising edge (one-cycle latency from inputs).
REQ-019 peripheralClkEdge held high for N consecutive cycles SHALL produce N shifts, one per cycle; no internal edge detection.
REQ-020 Inputs SHALL be sampled only at rising clk; changes between edges have no effect.
REQ-021 Any X/Z on unused data inputs (e.g. parallelDataIn during shift) SHALL NOT affect the register.

Reset
REQ-022 reset=1 at a rising clk SHALL clear the register to all zeros, overriding peripheralClkEdge and parallelLoad.
REQ-023 After reset: parallelDataOut = 0, serialDataOut = 0 until the next load or shift.
REQ-024 Reset asserted mid-sequence SHALL discard partially shifted data; no other state survives.
REQ-025 Register contents before the first reset are undefined; benches SHALL reset first.

Verification
REQ-026 Reset: reset=1 one edge with parallelLoad=1, parallelDataIn=8'hFF -> parallelDataOut=00000000, serialDataOut=0.
REQ-027 Parallel load: parallelLoad=1, peripheralClkEdge=0, parallelDataIn=10111010, one edge -> parallelDataOut=10111010, serialDataOut=1.
REQ-028 Shift: from 10111010, peripheralClkEdge=1, parallelLoad=0, serialDataIn=1, one edge -> parallelDataOut=01110101, serialDataOut=0.
REQ-029 Priority: from 01110101, parallelLoad=1, peripheralClkEdge=1, parallelDataIn=00000000, serialDataIn=0, one edge -> parallelDataOut=11101010 (shift wins), serialDataOut=1.
REQ-030 Hold: all controls 0 for 5 edges with changing parallelDataIn/serialDataIn -> parallelDataOut unchanged.
REQ-031 Serial stream: after reset, shift in 1,0,1,1,0,0,1,0 on 8 consecutive edges -> parallelDataOut=10110010; serialDataOut sequence after each edge = 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/shift_register.sv
// Shift register with parallel load, serial input at the LSB and serial output from the MSB.
// One register is the only state element. Each rising clk applies reset, then shift, then load, then hold.
module shift_register #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [width-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic [width-1:0] parallelDataOut,
    output logic             serialDataOut
);

    logic [width-1:0] shiftReg;
    logic [width-1:0] shiftReg_c;

    // Next-state selection. Data inputs are looked at only on the path that is taken,
    // so unknown values on data inputs that are not used cannot reach the register.
    always_comb begin
        shiftReg_c = shiftReg;
        if (peripheralClkEdge) begin
            shiftReg_c = {shiftReg[width-2:0], serialDataIn};
        end else if (parallelLoad) begin
            shiftReg_c = parallelDataIn;
        end
    end

    // Register update. A synchronous reset takes precedence over every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg <= '0;
        end else begin
            shiftReg <= shiftReg_c;
        end
    end

    // The outputs come straight from the register, with no extra pipeline stage.
    assign parallelDataOut = shiftReg;
    assign serialDataOut   = shiftReg[width-1];

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register. It has two parts.
// 1. A table of directed vectors, each with its expected output.
// 2. Hand-written multi-cycle sequences, whose expected values come from a reference model.
// Every expected value goes into a scoreboard queue and is checked after the clock edge.
module tb_shift_register;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         peripheralClkEdge;
    logic         parallelLoad;
    logic [W-1:0] parallelDataIn;
    logic         serialDataIn;
    logic [W-1:0] parallelDataOut;
    logic         serialDataOut;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic         rst;
        logic         shiftEn;
        logic         load;
        logic [W-1:0] pData;
        logic         sData;
        logic [W-1:0] expPar;
        logic         expSer;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] par;
        logic         ser;
        string        name;
    } exp_t;

    vec_t         vecs[$];
    exp_t         expQ[$];
    logic [W-1:0] modelReg;

    shift_register #(.width(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .peripheralClkEdge (peripheralClkEdge),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the oldest expected value and compares it with the current DUT outputs.
    task automatic checkOutputs();
        exp_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("FAIL scoreboard_empty: no expected entry for par=%h ser=%b", parallelDataOut, serialDataOut);
        end else begin
            e = expQ.pop_front();
            if (parallelDataOut !== e.par || serialDataOut !== e.ser) begin
                testsFailed++;
                $display("FAIL %s: got par=%b ser=%b, expected par=%b ser=%b",
                         e.name, parallelDataOut, serialDataOut, e.par, e.ser);
            end
        end
    endtask

    // Drives one cycle of inputs at the falling edge and advances the reference model.
    // It queues either the supplied expectation (useExp=1) or the model's prediction,
    // then checks the outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [W-1:0] pd, input logic sd,
                        input logic useExp, input logic [W-1:0] ePar, input logic eSer,
                        input string nm);
        exp_t x;
        @(negedge clk);
        reset             = r;
        peripheralClkEdge = e;
        parallelLoad      = l;
        parallelDataIn    = pd;
        serialDataIn      = sd;
        if (r)      modelReg = '0;
        else if (e) modelReg = {modelReg[W-2:0], sd};
        else if (l) modelReg = pd;
        x.par  = useExp ? ePar : modelReg;
        x.ser  = useExp ? eSer : modelReg[W-1];
        x.name = nm;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    initial begin
        logic [W-1:0] snap;
        logic [W-1:0] stream;

        reset = 1'b0;
        peripheralClkEdge = 1'b0;
        parallelLoad = 1'b0;
        parallelDataIn = '0;
        serialDataIn = 1'b0;
        modelReg = '0;

        // Fields: rst, shiftEn, load, pData, sData, expPar, expSer, name.
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'b00000000, 1'b0, "reset_over_load"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b10111010, 1'b0, 8'b10111010, 1'b1, "parallel_load"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'b01110101, 1'b0, "shift_one"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'b11101010, 1'b1, "shift_beats_load"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 8'b11101010, 1'b1, "hold_0"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h34, 1'b0, 8'b11101010, 1'b1, "hold_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h56, 1'b1, 8'b11101010, 1'b1, "hold_2"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h78, 1'b0, 8'b11101010, 1'b1, "hold_3"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h9A, 1'b1, 8'b11101010, 1'b1, "hold_4"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, "reset_over_shift"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, "stream_0"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, "stream_1"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, "stream_2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0B, 1'b0, "stream_3"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h16, 1'b0, "stream_4"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h2C, 1'b0, "stream_5"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h59, 1'b0, "stream_6"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'b10110010, 1'b1, "stream_7"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hxx, 1'b1, 8'b01100101, 1'b0, "shift_ignores_x_data"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hA5, 1'bx, 8'hA5, 1'b1, "load_ignores_x_serial"});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].shiftEn, vecs[i].load, vecs[i].pData, vecs[i].sData,
                 1'b1, vecs[i].expPar, vecs[i].expSer, vecs[i].name);
        end

        // Reset in the middle of a shift sequence throws away the partial data.
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "mid_shift_a");
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, "mid_shift_b");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, "mid_sequence_reset");
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, "after_reset_hold");

        // Controls that pulse between clock edges have no effect on the register.
        step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, '0, 1'b0, "preload_c3");
        snap = modelReg;
        #1;
        parallelLoad = 1'b1;
        peripheralClkEdge = 1'b1;
        parallelDataIn = 8'h3C;
        serialDataIn = 1'b1;
        #2;
        parallelLoad = 1'b0;
        peripheralClkEdge = 1'b0;
        testsRun++;
        if (parallelDataOut !== snap) begin
            testsFailed++;
            $display("FAIL between_edge_glitch: got par=%b, expected par=%b", parallelDataOut, snap);
        end
        step(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 8'hC3, 1'b1, "glitch_then_hold");

        // Holding the shift enable high gives one shift per cycle, with random serial bits.
        stream = W'($urandom);
        for (int k = 0; k < 2 * W; k++) begin
            step(1'b0, 1'b1, k[0], W'($urandom), stream[k % W], 1'b0, '0, 1'b0, "held_shift");
        end

        // Random mix of controls checked against the reference model.
        for (int k = 0; k < 40; k++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), W'($urandom),
                 1'($urandom), 1'b0, '0, 1'b0, "random_mix");
        end

        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
